// File: rtl/seg7_pkg.sv
// Seven-segment shared constants: segment bit positions and hex glyph table.
// Patterns are true polarity, bit0=a .. bit6=g.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Index 15 is leftmost in the concatenation.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph, true polarity.
// Pure table lookup into the shared glyph table.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Multiplexed seven-segment scanner with frame-shadowed inputs,
// leading-zero blanking, per-digit enable and PWM brightness.
module seven_seg_scan_mux
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_digit_en,
    input  logic                  i_lz_blank,
    input  logic [3:0]            i_brightness,
    input  logic                  i_invert_seg,
    input  logic                  i_invert_dig,
    output logic [SEG_W-1:0]      o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_digit,
    output logic                  o_frame_start
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [DIV_LOG2-1:0]   cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] sh_value;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_en;
    logic                  sh_lz;
    logic [3:0]            sh_bri;

    logic                  load;
    logic                  wrap;
    logic [3:0]            phase;
    logic [3:0]            nib;
    logic                  dp_sel;
    logic                  en_sel;
    logic                  blank;
    logic                  lead;
    logic                  lit;
    logic [N_DIGITS-1:0]   sel;
    logic [SEG_W-1:0]      pat;

    assign load  = (cnt == '0) && (idx == '0);
    assign wrap  = &cnt;
    assign phase = cnt[DIV_LOG2-1 -: 4];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + DIV_LOG2'(1);
            if (wrap)
                idx <= (idx == IW'(N_DIGITS-1)) ? '0 : idx + IW'(1);
        end
    end

    // Inputs are sampled once per frame so a frame never mixes old and new data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sh_value      <= '0;
            sh_dp         <= '0;
            sh_en         <= '0;
            sh_lz         <= 1'b0;
            sh_bri        <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= load;
            if (load) begin
                sh_value <= i_value;
                sh_dp    <= i_dp;
                sh_en    <= i_digit_en;
                sh_lz    <= i_lz_blank;
                sh_bri   <= i_brightness;
            end
        end
    end

    // Walk from the top digit down; lead stays set while every nibble so far is zero.
    always_comb begin
        nib    = '0;
        dp_sel = 1'b0;
        en_sel = 1'b0;
        blank  = 1'b0;
        sel    = '0;
        lead   = 1'b1;
        for (int k = N_DIGITS-1; k >= 0; k--) begin
            if (sh_value[k*4 +: 4] != 4'h0)
                lead = 1'b0;
            if (idx == IW'(k)) begin
                nib    = sh_value[k*4 +: 4];
                dp_sel = sh_dp[k];
                en_sel = sh_en[k];
                sel[k] = 1'b1;
                blank  = sh_lz && lead && (k != 0);
            end
        end
    end

    assign lit = en_sel && (phase != 4'h0) && (phase <= sh_bri);

    seg7_hex_decode u_dec (
        .nibble (nib),
        .seg    (pat)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_seg   <= {SEG_W{i_invert_seg}};
            o_dp    <= i_invert_seg;
            o_digit <= {N_DIGITS{i_invert_dig}};
        end else begin
            o_seg   <= ((lit && !blank) ? pat : '0) ^ {SEG_W{i_invert_seg}};
            o_dp    <= (lit && dp_sel) ^ i_invert_seg;
            o_digit <= (lit ? sel : '0) ^ {N_DIGITS{i_invert_dig}};
        end
    end

endmodule

// File: doc/seven_seg_scan_mux.md
SEVEN_SEG_SCAN_MUX -- requirements
Module: seven_seg_scan_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter DIV_LOG2, default 10, log2 of clock cycles per digit slot, legal range 4..24.
REQ-003 SHALL have port i_clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_value  in  4*N_DIGITS  hex nibbles; nibble k drives digit k (digit 0 = least significant).
REQ-006 SHALL have port i_dp  in  N_DIGITS  decimal-point request per digit.
REQ-007 SHALL have port i_digit_en  in  N_DIGITS  per-digit enable.
REQ-008 SHALL have port i_lz_blank  in  1  leading-zero blanking mode.
REQ-009 SHALL have port i_brightness  in  4  on-time level 0..15.
REQ-010 SHALL have port i_invert_seg  in  1  segment and dp polarity; 1 = active-low pins.
REQ-011 SHALL have port i_invert_dig  in  1  digit-select polarity; 1 = active-low pins.
REQ-012 SHALL have port o_seg  out  7  segments, bit0=a .. bit6=g.
REQ-013 SHALL have port o_dp  out  1  decimal point.
REQ-014 SHALL have port o_digit  out  N_DIGITS  one-hot-or-zero digit select (before inversion).
REQ-015 SHALL have port o_frame_start  out  1  one-cycle pulse per frame.

Function
REQ-016 SHALL run a DIV_LOG2-bit prescaler 0..2^DIV_LOG2-1, wrapping, and a digit index 0..N_DIGITS-1 that increments when the prescaler wraps and wraps from N_DIGITS-1 to 0.
REQ-017 SHALL define phase = prescaler[DIV_LOG2-1 -: 4]; a digit is lit only while phase != 0 and phase <= shadow brightness (0 = dark, 15 = 15/16 duty).
REQ-018 SHALL load shadow copies of i_value, i_dp, i_digit_en, i_lz_blank, i_brightness on every cycle where prescaler==0 and index==0; inputs are ignored at all other times (tear-free frames).
REQ-019 SHALL register o_frame_start high for exactly one cycle, the cycle after each shadow load.
REQ-020 SHALL decode nibbles as hex 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, gfedcba).
REQ-021 SHALL, with shadow lz_blank=1, blank digit k (segments off, select still driven) when nibbles N_DIGITS-1..k are all zero and k != 0; digit 0 is never blanked.
REQ-022 SHALL keep digit k dark for its whole slot when shadow digit_en[k]=0; the slot is still consumed (frame period constant).
REQ-023 SHALL drive o_dp active when digit lit and shadow dp[k]=1, independent of leading-zero blanking.
REQ-024 SHALL drive all of o_seg, o_dp, o_digit inactive whenever no digit is lit.
REQ-025 SHALL register o_seg, o_dp, o_digit: pins reflect internal state with exactly 1 cycle latency.
REQ-026 SHALL apply i_invert_seg to o_seg and o_dp, i_invert_dig to o_digit, at the output register input; inversion inputs are not shadowed.
REQ-027 SHALL give frame period N_DIGITS*2^DIV_LOG2 cycles; the phase-0 interval guarantees >= 2^(DIV_LOG2-4) dead cycles between digits.

Reset
REQ-028 SHALL, while i_rst_n==0 at a clock edge, set prescaler=0, index=0, all shadows=0, o_frame_start=0.
REQ-029 SHALL, while in reset, load o_seg={7{i_invert_seg}}, o_dp=i_invert_seg, o_digit={N_DIGITS{i_invert_dig}} (all inactive).
REQ-030 SHALL, on release, start at prescaler 0, index 0, load shadows in the first cycle, and pulse o_frame_start the next cycle; reset mid-frame abandons the frame with no partial-slot output.

Structure
REQ-031 SHALL place the 16-entry segment table and segment bit-index constants in shared package seg7_pkg.
REQ-032 SHALL use one combinational sub-module, seg7_hex_decode (4-bit nibble -> 7-bit pattern, true polarity); scan, shadowing, PWM in the top.

Verification (N_DIGITS=4, DIV_LOG2=4, slot 16 cycles, frame 64)
REQ-033 SHALL test reset: rst_n low 3 cycles, invert_seg=1, invert_dig=0 -> o_seg=7F, o_dp=1, o_digit=0000 during reset and first cycle after.
REQ-034 SHALL test scan: value=12AF, en=F, brightness=15 -> digit0 0001/71, digit1 0010/77, digit2 0100/5B, digit3 1000/06, each lit 15 of 16 cycles; o_frame_start every 64 cycles.
REQ-035 SHALL test PWM: brightness=4 -> each digit lit exactly 4 consecutive cycles (phases 1..4) per slot, dark 12.
REQ-036 SHALL test blanking: lz_blank=1, value=0070 -> digits 3,2 segments 00, digit1 07, digit0 3F; value=0000 -> only digit0 shows 3F; dp[3]=1 still lights o_dp on digit3.
REQ-037 SHALL test tearing/enable: change value during digit1 slot -> no pin change until after next o_frame_start; en=1011 -> digit2 select never asserted, frame still 64 cycles.
REQ-038 SHALL test reset mid-frame: rst_n low during digit2 slot -> outputs inactive next cycle; after release scan restarts at digit0 with fresh shadows.
